// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: decoded ID/EX/MEM info in, stage controls out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CntWidth = 16
);
  logic [4:0]          rs1_ID;
  logic [4:0]          rs2_ID;
  logic                rs1_used_ID;
  logic                rs2_used_ID;
  logic [4:0]          rd_EX;
  logic                RegWEn_EX;
  logic                load_EX;
  logic                PCSel_EX;
  logic                dmem_req_MEM;
  logic                dmem_ack_i;
  logic                pc_en_o;
  logic                ifid_en_o;
  logic                ifid_flush_o;
  logic                idex_en_o;
  logic                idex_flush_o;
  logic                exmem_en_o;
  logic [CntWidth-1:0] stall_cnt_o;
  logic [CntWidth-1:0] flush_cnt_o;
  logic                mem_timeout_o;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, RegWEn_EX, load_EX, PCSel_EX,
    output dmem_req_MEM, dmem_ack_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o,
    input  stall_cnt_o, flush_cnt_o, mem_timeout_o
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, RegWEn_EX, load_EX, PCSel_EX,
    input  dmem_req_MEM, dmem_ack_i,
    output pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o,
    output stall_cnt_o, flush_cnt_o, mem_timeout_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, redirect squashes, dmem wait freezes,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned FlushCycles = 1,
  parameter int unsigned MemTimeout  = 255,
  parameter int unsigned CntWidth    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

  state_e              r_state_q, w_state_d;
  state_e              r_ret_q, w_ret_d;
  logic [2:0]          r_fcnt_q, w_fcnt_d;
  logic [15:0]         r_wait_q, w_wait_d;
  logic                r_to_q;
  logic [CntWidth-1:0] r_stall_q, r_flush_q;

  logic w_mem_wait, w_lu, w_redirect;
  logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_en;

  assign w_mem_wait = bus.dmem_req_MEM & ~bus.dmem_ack_i;
  assign w_lu = bus.load_EX & bus.RegWEn_EX & (bus.rd_EX != 5'd0) &
                ((bus.rs1_used_ID & (bus.rs1_ID == bus.rd_EX)) |
                 (bus.rs2_used_ID & (bus.rs2_ID == bus.rd_EX)));

  always_comb begin
    w_pc_en      = 1'b0;
    w_ifid_en    = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_en    = 1'b0;
    w_idex_flush = 1'b0;
    w_exmem_en   = 1'b0;
    w_redirect   = 1'b0;
    w_state_d    = r_state_q;
    w_ret_d      = r_ret_q;
    w_fcnt_d     = r_fcnt_q;
    w_wait_d     = r_wait_q;
    unique case (r_state_q)
      StRun: begin
        if (w_mem_wait) begin
          w_state_d = StMemWait;
          w_ret_d   = StRun;
          w_wait_d  = 16'd1;
        end else begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b1111;
          if (bus.PCSel_EX) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_redirect   = 1'b1;
            if (FlushCycles != 0) begin
              w_state_d = StFlush;
              w_fcnt_d  = 3'(FlushCycles);
            end
          end else if (w_lu) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX while the load moves on.
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
          end
        end
      end
      StFlush: begin
        if (w_mem_wait) begin
          w_state_d = StMemWait;
          w_ret_d   = StFlush;
          w_wait_d  = 16'd1;
        end else begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b1111;
          w_ifid_flush = 1'b1;
          w_fcnt_d     = r_fcnt_q - 3'd1;
          if (r_fcnt_q == 3'd1) w_state_d = StRun;
        end
      end
      StMemWait: begin
        if (w_mem_wait) begin
          if (r_wait_q < 16'(MemTimeout)) w_wait_d = r_wait_q + 16'd1;
        end else begin
          // Ack, or the request dropping, both count as completion.
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b1111;
          w_state_d = r_ret_q;
          w_wait_d  = 16'd0;
        end
      end
      default: w_state_d = StRun;
    endcase
    if (!rst_ni) begin
      {w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_en} = 6'b0;
      w_redirect = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q <= StRun;
      r_ret_q   <= StRun;
      r_fcnt_q  <= 3'd0;
      r_wait_q  <= 16'd0;
      r_to_q    <= 1'b0;
      r_stall_q <= '0;
      r_flush_q <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_ret_q   <= w_ret_d;
      r_fcnt_q  <= w_fcnt_d;
      r_wait_q  <= w_wait_d;
      r_to_q    <= r_to_q | (w_wait_d == 16'(MemTimeout));
      if (!w_pc_en && (r_stall_q != {CntWidth{1'b1}})) r_stall_q <= r_stall_q + 1'b1;
      if (w_redirect && (r_flush_q != {CntWidth{1'b1}})) r_flush_q <= r_flush_q + 1'b1;
    end
  end

  assign bus.pc_en_o       = w_pc_en;
  assign bus.ifid_en_o     = w_ifid_en;
  assign bus.ifid_flush_o  = w_ifid_flush;
  assign bus.idex_en_o     = w_idex_en;
  assign bus.idex_flush_o  = w_idex_flush;
  assign bus.exmem_en_o    = w_exmem_en;
  assign bus.stall_cnt_o   = r_stall_q;
  assign bus.flush_cnt_o   = r_flush_q;
  assign bus.mem_timeout_o = r_to_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int unsigned FlushCycles = 2;
  localparam int unsigned MemTimeout  = 8;
  localparam int unsigned CntWidth    = 8;
  localparam int          CntMax      = (1 << CntWidth) - 1;

  typedef struct packed {
    logic [5:0]          ctl;  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
    logic [CntWidth-1:0] stall;
    logic [CntWidth-1:0] flush;
    logic                to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CntWidth(CntWidth)) bus ();

  pipe_hazard_ctrl #(
    .FlushCycles(FlushCycles),
    .MemTimeout (MemTimeout),
    .CntWidth   (CntWidth)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state, described by what the pipeline is doing rather than by FSM encoding.
  int squash_left = 0;   // squash-only cycles still owed to the last redirect
  bit waiting     = 0;   // pipeline frozen on data memory
  int wait_cycles = 0;
  bit timeout     = 0;
  int stall_n     = 0;
  int flush_n     = 0;

  task automatic drive(input bit rst, input bit [4:0] rs1, input bit [4:0] rs2, input bit u1,
                       input bit u2, input bit [4:0] rd, input bit we, input bit ld,
                       input bit pc, input bit req, input bit ack);
    exp_t e;
    bit   mw, lu;
    @(negedge clk);
    rst_n            = rst;
    bus.rs1_ID       = rs1;
    bus.rs2_ID       = rs2;
    bus.rs1_used_ID  = u1;
    bus.rs2_used_ID  = u2;
    bus.rd_EX        = rd;
    bus.RegWEn_EX    = we;
    bus.load_EX      = ld;
    bus.PCSel_EX     = pc;
    bus.dmem_req_MEM = req;
    bus.dmem_ack_i   = ack;
    #1;
    mw = req && !ack;
    lu = ld && we && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.stall = CntWidth'(stall_n);
    e.flush = CntWidth'(flush_n);
    e.to    = timeout;
    if (!rst)               e.ctl = 6'b000000;
    else if (mw)            e.ctl = 6'b000000;
    else if (waiting)       e.ctl = 6'b110101;
    else if (squash_left > 0) e.ctl = 6'b111101;
    else if (pc)            e.ctl = 6'b111111;
    else if (lu)            e.ctl = 6'b000111;
    else                    e.ctl = 6'b110101;
    q.push_back(e);
    if (!rst) begin
      squash_left = 0; waiting = 0; wait_cycles = 0; timeout = 0; stall_n = 0; flush_n = 0;
    end else begin
      if (!e.ctl[5] && stall_n < CntMax) stall_n++;
      if (waiting) begin
        if (mw) begin
          if (wait_cycles < MemTimeout) wait_cycles++;
        end else begin
          waiting = 0;
          wait_cycles = 0;
        end
      end else if (mw) begin
        waiting = 1;
        wait_cycles = 1;
      end else if (squash_left > 0) begin
        squash_left--;
      end else if (pc) begin
        if (flush_n < CntMax) flush_n++;
        squash_left = FlushCycles;
      end
      if (wait_cycles >= MemTimeout) timeout = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle();
    drive(($urandom_range(0, 49) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
  endtask

  // Monitor: controls are valid every cycle, so compare everything the driver has queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({bus.pc_en_o, bus.ifid_en_o, bus.ifid_flush_o, bus.idex_en_o, bus.idex_flush_o,
             bus.exmem_en_o} !== e.ctl) begin
          n_errors++;
          $display("FAIL ctl @%0t: got %b want %b", $time, {bus.pc_en_o, bus.ifid_en_o,
                   bus.ifid_flush_o, bus.idex_en_o, bus.idex_flush_o, bus.exmem_en_o}, e.ctl);
        end
        n_checks++;
        if (bus.stall_cnt_o !== e.stall) begin
          n_errors++;
          $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, bus.stall_cnt_o, e.stall);
        end
        n_checks++;
        if (bus.flush_cnt_o !== e.flush) begin
          n_errors++;
          $display("FAIL flush_cnt @%0t: got %0d want %0d", $time, bus.flush_cnt_o, e.flush);
        end
        n_checks++;
        if (bus.mem_timeout_o !== e.to) begin
          n_errors++;
          $display("FAIL mem_timeout @%0t: got %b want %b", $time, bus.mem_timeout_o, e.to);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on rs1, then the x0 and unused-rs2 filters.
    drive(1, 5, 1, 1, 1, 5, 1, 1, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    drive(1, 1, 7, 1, 0, 7, 1, 1, 0, 0, 0);
    idle(1);
    // Redirect pulse.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    // Redirect + load-use + mem wait together; ack on the fifth cycle, redirect still pending.
    for (int i = 0; i < 4; i++) drive(1, 5, 0, 1, 0, 5, 1, 1, 1, 1, 0);
    drive(1, 5, 0, 1, 0, 5, 1, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    // Timeout, sticky across ack, cleared by reset.
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Mem wait entered mid-flush returns to flushing; then reset during a wait.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 2000; i++) rand_cycle();
    // Saturate the flush counter, then the stall counter.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 900; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    for (int i = 0; i < 500; i++) rand_cycle();
    @(negedge clk);
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard drain: got %0d entries left want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequences the five-stage RV32I pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.
- Generates per-stage enables and squash (bubble) controls for three cases: load-use hazards, taken branches/jumps resolved in EX, and data-memory wait states.
- Sits beside the ID/EX register. It consumes decoded register indices from ID and control flags from EX/MEM, and drives the enable/flush inputs of every pipeline register.
- Also exports stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
FlushCycles, 1, extra squash cycles after a taken redirect (fetch latency beyond one stage); range 0..7
MemTimeout, 255, max consecutive MEM_WAIT cycles before mem_timeout_o sets; range 1..65535
CntWidth, 16, width of performance counters

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  synchronous active-low reset
rs1_ID  in  5  rs1 index of instruction in ID
rs2_ID  in  5  rs2 index of instruction in ID
rs1_used_ID  in  1  instruction in ID reads rs1
rs2_used_ID  in  1  instruction in ID reads rs2
rd_EX  in  5  destination index of instruction in EX
RegWEn_EX  in  1  instruction in EX writes rd
load_EX  in  1  instruction in EX is a load (WBSel selects memory)
PCSel_EX  in  1  taken branch/jump resolved in EX this cycle
dmem_req_MEM  in  1  instruction in MEM accesses data memory
dmem_ack_i  in  1  data memory completes access this cycle
pc_en_o  out  1  PC register update enable
ifid_en_o  out  1  IF/ID register load enable
ifid_flush_o  out  1  IF/ID loads NOP (overrides enable)
idex_en_o  out  1  ID/EX register load enable
idex_flush_o  out  1  ID/EX loads all-zero control (bubble)
exmem_en_o  out  1  EX/MEM register load enable
stall_cnt_o  out  CntWidth  cycles with pc_en_o=0, saturating
flush_cnt_o  out  CntWidth  redirect events accepted, saturating
mem_timeout_o  out  1  sticky: memory wait exceeded MemTimeout

Behaviour:
- Reset: rst_ni sampled low at a rising edge sets state=RUN, the flush counter to 0, the wait counter to 0, stall_cnt_o=0, flush_cnt_o=0 and mem_timeout_o=0. While rst_ni=0, all enables=0 and all flushes=0.
- Outputs: combinational functions of state and current inputs. Counters and flags are registered.
- States: RUN, FLUSH, MEM_WAIT. Priority when events coincide: memory wait > redirect > load-use.
- Memory wait: mem_wait = dmem_req_MEM & ~dmem_ack_i.
- Load-use hazard: lu = load_EX & RegWEn_EX & (rd_EX!=0) & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
- RUN:
  - Default: all enables=1, flushes=0.
  - If mem_wait: all enables=0, flushes=0; next state=MEM_WAIT; wait counter=1.
  - Else if PCSel_EX: all enables=1, ifid_flush_o=1, idex_flush_o=1; flush_cnt_o+1. Next state=FLUSH with count=FlushCycles, or RUN if FlushCycles=0.
  - Else if lu: pc_en_o=0, ifid_en_o=0, idex_flush_o=1, exmem_en_o=1. This is a one-cycle bubble; the hazard clears once the load reaches MEM. Stay in RUN.
- FLUSH:
  - Enables=1, ifid_flush_o=1, idex_flush_o=0. Count decrements; go to RUN when count reaches 1.
  - lu is ignored, because the ID instruction is being squashed.
  - A new PCSel_EX cannot occur, since EX holds a bubble. If it is asserted anyway, ignore it.
  - mem_wait (from an older instruction) takes priority: freeze with all enables=0 and ifid_flush_o=0. Count is held; go to MEM_WAIT, then return to FLUSH.
- MEM_WAIT:
  - All enables=0, flushes=0; wait counter increments, saturating at MemTimeout.
  - When the counter reaches MemTimeout, mem_timeout_o sets. It clears only on reset.
  - On dmem_ack_i: enables=1 in that same cycle. Next state = the saved return state (RUN or FLUSH); wait counter=0.
  - If dmem_req_MEM drops without an ack, treat it as completion.
- stall_cnt_o increments each cycle pc_en_o=0 (including MEM_WAIT and load-use) and saturates at all-ones. flush_cnt_o also saturates.
- Reset asserted mid-FLUSH or mid-MEM_WAIT: state returns to RUN next edge; no residual flush.

Test Plan:
- Load-use: EX holds lw x5 with load_EX=1, RegWEn_EX=1, rd_EX=5, and ID holds add x6,x5,x1 (rs1_ID=5, rs1_used_ID=1) -> exactly one cycle of pc_en_o=0, ifid_en_o=0, idex_flush_o=1; stall_cnt_o=1; next cycle all enables=1.
- x0 and unused-operand filter: rd_EX=0 with a load in EX, or rs2_ID=rd_EX but rs2_used_ID=0 -> no stall; stall_cnt_o stays 0.
- Redirect with FlushCycles=2: PCSel_EX pulse -> ifid_flush_o=1 for 3 consecutive cycles, idex_flush_o=1 only in the first; flush_cnt_o=1; back to RUN.
- Simultaneous events: PCSel_EX=1, lu=1 and mem_wait=1 in the same cycle -> freeze (all enables 0); ack after 4 cycles -> the redirect flush is then applied; stall_cnt_o=4.
- Timeout with MemTimeout=8: dmem_req_MEM=1 and no ack for 10 cycles -> mem_timeout_o=1 from the 8th wait cycle and stays set after ack; cleared only by rst_ni=0.
- Reset during MEM_WAIT: rst_ni low for 1 cycle -> state RUN, counters 0, mem_timeout_o=0, all enables 1 after release.
